// File: rtl/spi_target_bridge.sv
// SPI target (CPOL selectable, CPHA=0) that bridges host bytes to a CPU register pair.
// All SPI pins are oversampled in the system clock domain.
module spi_target_bridge #(
  parameter bit          POLARITY    = 1'b1,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sys_we,
  input  logic [7:0] sys_wdata,
  input  logic       sys_rd,
  output logic [7:0] sys_rdata,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic       selected,
  output logic       frame_end,
  input  logic       spi_sck,
  input  logic       spi_ss,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   lead_edge, trail_edge, ss_fall, ss_rise;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [6:0]  rx_shift_q;
  logic [7:0]  tx_shift_q, hold_q, rdata_q;
  logic        rx_valid_q, rx_overrun_q, tx_ready_q, tx_underrun_q;
  logic        selected_q, frame_end_q, oe_q;
  logic        load_en, byte_done;
  logic [7:0]  load_byte, rx_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= {SYNC_STAGES{POLARITY}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= POLARITY;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    ss_s       = ss_sync_q[SYNC_STAGES-1];
    mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    lead_edge  = (sck_s != POLARITY) && (sck_prev_q == POLARITY);
    trail_edge = (sck_s == POLARITY) && (sck_prev_q != POLARITY);
    ss_fall    = ss_prev_q && !ss_s;
    ss_rise    = !ss_prev_q && ss_s;
    load_byte  = tx_ready_q ? FILL_BYTE : hold_q;
    rx_byte    = {rx_shift_q, mosi_s};
    // Counter is 0 on a trailing edge only right after a byte completed.
    load_en    = ((state_q == StIdle) && ss_fall) ||
                 ((state_q == StActive) && !ss_rise && trail_edge && (cnt_q == 3'd0));
    byte_done  = (state_q == StActive) && !ss_rise && lead_edge && (cnt_q == 3'd7);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 3'd0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      hold_q        <= '0;
      rdata_q       <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      selected_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      oe_q          <= 1'b0;
    end else begin
      frame_end_q <= 1'b0;

      // A CPU write always wins the holding register over a concurrent load.
      if (sys_we) begin
        hold_q     <= sys_wdata;
        tx_ready_q <= 1'b0;
      end else if (load_en) begin
        tx_ready_q <= 1'b1;
      end
      if (load_en && tx_ready_q) tx_underrun_q <= 1'b1;
      else if (sys_we)           tx_underrun_q <= 1'b0;

      if (byte_done) begin
        rdata_q      <= rx_byte;
        rx_valid_q   <= 1'b1;
        rx_overrun_q <= !sys_rd && (rx_overrun_q || rx_valid_q);
      end else if (sys_rd) begin
        rx_valid_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (ss_fall) begin
            state_q    <= StActive;
            selected_q <= 1'b1;
            oe_q       <= 1'b1;
            cnt_q      <= 3'd0;
            tx_shift_q <= load_byte;
          end
        end
        StActive: begin
          if (ss_rise) begin
            state_q     <= StIdle;
            selected_q  <= 1'b0;
            oe_q        <= 1'b0;
            cnt_q       <= 3'd0;
            frame_end_q <= 1'b1;
          end else if (lead_edge) begin
            rx_shift_q <= rx_byte[6:0];
            cnt_q      <= cnt_q + 3'd1;
          end else if (trail_edge) begin
            tx_shift_q <= load_en ? load_byte : {tx_shift_q[6:0], 1'b0};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sys_rdata   = rdata_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign selected    = selected_q;
  assign frame_end   = frame_end_q;
  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = oe_q;

endmodule
